// File: rtl/ir_transmitter.sv
// IrDA SIR byte transmitter: frames a byte as start, 8 data bits (LSB first),
// parity and stop, and drives a short IR pulse for every 0-valued bit period.
// tx_done and tx_available are both high on the last clock of a frame. A send
// sampled on that clock starts the next frame with no idle gap in between.
module ir_transmitter #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PULSE_CLKS   = (CLKS_PER_BIT * 3) / 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       send,
    output logic       ir_tx,
    output logic       tx_available,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_LAST   = cnt_t'(CLKS_PER_BIT - 1);
    localparam cnt_t PULSE_END  = cnt_t'(PULSE_CLKS);
    localparam logic PARITY_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q;
    logic       parity_q;
    logic       accept;
    logic       cnt_last;
    logic       next_bit;
    logic       ir_tx_d;
    logic       frame_end_d;

    assign cnt_last = (cnt_q == CNT_LAST);

    // Next-state logic: advance the bit-period counter, step through the
    // frame fields, and accept a new byte when idle or on the final clock.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = send;
            end
            START: begin
                if (cnt_last) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            STOP: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    accept  = send;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d   = START;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
        end
    end

    // Output look-ahead: the value of the bit period about to run and
    // whether the coming clock is the final one of the frame, so the
    // outputs can be registered without a cycle of lag.
    always_comb begin
        next_bit = 1'b1;
        unique case (state_d)
            START:   next_bit = 1'b0;
            DATA:    next_bit = data_q[bit_idx_d];
            PARITY:  next_bit = parity_q;
            default: next_bit = 1'b1;
        endcase
        ir_tx_d     = (state_d != IDLE) && !next_bit && (cnt_d < PULSE_END);
        frame_end_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    // State, counters, byte/parity latches and registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            data_q       <= 8'h00;
            parity_q     <= 1'b0;
            ir_tx        <= 1'b0;
            tx_available <= 1'b1;
            tx_done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            if (accept) begin
                data_q   <= tx_data;
                parity_q <= (^tx_data) ^ PARITY_INV;
            end
            ir_tx        <= ir_tx_d;
            tx_done      <= frame_end_d;
            tx_available <= (state_d == IDLE) || frame_end_d;
        end
    end

endmodule

// File: doc/ir_transmitter.md
IR_TRANSMITTER -- requirements
Module: ir_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600 baud); legal range 16 or more.
REQ-002 Parameter PULSE_CLKS, (CLKS_PER_BIT*3)/16, IR pulse width in clocks for a 0 bit; legal range 1 to CLKS_PER_BIT-1.
REQ-003 Parameter PARITY_ODD, 0, selects parity: 0 = even, 1 = odd.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-007 send  input  1  transmit request; level-sampled.
REQ-008 ir_tx  output  1  IrDA SIR drive to the IR LED; 1 = LED on.
REQ-009 tx_available  output  1  1 = idle, ready to accept send.
REQ-010 tx_done  output  1  one-cycle strobe at the end of each frame.

Function
REQ-011 The frame SHALL be 11 bit periods: start (0), tx_data[0..7] LSB first, parity, stop (1).
REQ-012 The parity bit SHALL be the XOR of the 8 data bits when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-013 Encoding: each 0-valued bit period SHALL drive ir_tx=1 for the first PULSE_CLKS clocks of the period, then 0 for the rest of the period.
REQ-014 Each 1-valued bit period, including stop, SHALL keep ir_tx=0 for the whole period.
REQ-015 ir_tx SHALL be registered (glitch-free) and SHALL be 0 whenever the block is idle.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-017 The clock counter SHALL run from 0 to CLKS_PER_BIT-1 in each state; the bit index SHALL run from 0 to 7 in DATA.
REQ-018 Acceptance: with the FSM in IDLE and send=1 at a clock edge, the block SHALL latch tx_data and the computed parity, go to START, and clear tx_available.
REQ-019 The first START clock (ir_tx=1) SHALL be the cycle immediately after acceptance.
REQ-020 Transitions SHALL occur when the clock counter equals CLKS_PER_BIT-1: START to DATA; DATA to DATA with the bit index incremented; DATA with bit index 7 to PARITY; PARITY to STOP; STOP to IDLE.
REQ-021 On entry to IDLE, tx_available SHALL be 1 and tx_done SHALL be 1 for exactly one cycle.
REQ-022 The acceptance-to-tx_done latency SHALL be exactly 11*CLKS_PER_BIT clocks.
REQ-023 send=1 while the block is not in IDLE SHALL be ignored: no queuing and no effect on the frame in progress.
REQ-024 A change on tx_data after acceptance SHALL NOT affect the frame in progress.
REQ-025 Back-to-back frames: send=1 in the tx_done cycle SHALL be accepted, and the next START SHALL follow with no idle bit period between frames.
REQ-026 send held high continuously SHALL produce contiguous frames, each carrying tx_data as sampled at its own acceptance.

Reset
REQ-027 Reset SHALL force: state IDLE, counters 0, ir_tx=0, tx_available=1, tx_done=0, and the data/parity latches to 0.
REQ-028 Reset SHALL take priority over send in the same cycle; that send SHALL NOT be accepted.
REQ-029 Reset mid-frame SHALL abort the frame immediately: ir_tx=0 from the next cycle, no tx_done, and a new send is accepted on the first cycle after reset deasserts.

Verification (CLKS_PER_BIT=16, PULSE_CLKS=3)
REQ-030 Reset, then send 0x55 (PARITY_ODD=0) -> pulses in bit periods 0, 2, 4, 6, 8 and 9 (6 pulses, each 3 clocks long, starting at offsets 1, 33, 65, 97, 129 and 145 after acceptance); tx_done exactly 176 clocks after acceptance.
REQ-031 Send 0x00 -> 10 pulses (start + 8 data + parity), none in the stop period; send 0xFF -> 2 pulses (start, parity); 0xFF with PARITY_ODD=1 -> 1 pulse (start only).
REQ-032 Pulse send while busy, and change tx_data mid-frame -> frame unchanged, no second frame, tx_available stays 0 until tx_done.
REQ-033 send held high with 0xA3 and then 0x3C -> two contiguous frames, second START at clock 176, 352 clocks total, tx_done twice.
REQ-034 Assert reset at clock 70 of a frame -> ir_tx=0 and tx_available=1 on the next cycle, no tx_done; the next send after reset gives a clean full frame.
